// File: rtl/opdec_pkg.sv
// opdec_pkg: constants and types shared by the op stream decoder.
//   - Opcode bytes, checked against op[15:8], and the full power-on word.
//   - audio_mode encodings. The FSM state values equal these encodings, so
//     audio_mode is the state register itself.
//   - classify_op(): maps a 16-bit op word to its op class.
package opdec_pkg;

    localparam logic [7:0]  OP_START22  = 8'h1f;
    localparam logic [7:0]  OP_START44  = 8'h0f;
    localparam logic [7:0]  OP_SAMPLE   = 8'hc7;
    localparam logic [7:0]  OP_ALL1     = 8'hff;
    localparam logic [15:0] OP_POWER_ON = 16'hc5ef;

    localparam logic [1:0] AUDIO_IDLE = 2'b00;
    localparam logic [1:0] AUDIO_22K  = 2'b01;
    localparam logic [1:0] AUDIO_44K  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = AUDIO_IDLE,
        ST_RUN22 = AUDIO_22K,
        ST_RUN44 = AUDIO_44K
    } state_t;

    typedef enum logic [2:0] {
        OPC_UNKNOWN,
        OPC_START22,
        OPC_START44,
        OPC_SAMPLE,
        OPC_ALL1,
        OPC_POWER_ON
    } op_class_t;

    // The power-on word is matched in full first. Its high byte (0xc5) does
    // not collide with any other opcode byte.
    function automatic op_class_t classify_op(input logic [15:0] w);
        op_class_t c;
        c = OPC_UNKNOWN;
        if (w == OP_POWER_ON) begin
            c = OPC_POWER_ON;
        end else begin
            case (w[15:8])
                OP_START22: c = OPC_START22;
                OP_START44: c = OPC_START44;
                OP_SAMPLE:  c = OPC_SAMPLE;
                OP_ALL1:    c = OPC_ALL1;
                default:    c = OPC_UNKNOWN;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO for the decoded sample bytes.
// Parameters: DEPTH (power of two, >= 2), WIDTH (data width).
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   push/push_data write one entry (ignored when full)
//   pop/pop_data   pop_data always shows the head entry; pop removes it
//                  (ignored when empty)
//   flush          empties the FIFO; wins over a push or pop in the same cycle
//   full, empty    occupancy flags
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    input  logic             flush,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The storage needs no reset: count and the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/op_stream_decoder.sv
// op_stream_decoder: decodes a stream of 16-bit op words into audio mode
// control, event pulses and a buffered stream of sample bytes.
// Optional feature: define OPDEC_STATS_EN to add the unknown_count output.
// Parameters:
//   FIFO_DEPTH  sample FIFO entries (power of two, >= 2)
//   RESET_RUN   consecutive all-1 ops that trigger a soft reset (>= 1)
//   TIMEOUT_CYC idle cycles in an audio mode before returning to idle (>= 2)
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   op_valid, op, op_ready            op word input handshake
//   sample_valid, sample_data,
//   sample_ready                      sample byte output handshake
//   audio_mode                        00 idle, 01 22 kHz, 10 44 kHz (FSM state)
//   audio_start_pulse, power_on_pulse,
//   soft_reset_pulse                  one-cycle event pulses
//   orphan_sample                     sticky: a sample op arrived while idle
//   unknown_count                     (OPDEC_STATS_EN) saturating unknown-op count
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. A valid source holds its data stable until that edge; ready may
// change at any time and does not depend on valid. op_ready is !fifo_full;
// sample_valid is !fifo_empty.
module op_stream_decoder
    import opdec_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int RESET_RUN   = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [15:0] op,
    output logic        op_ready,
    output logic        sample_valid,
    output logic [7:0]  sample_data,
    input  logic        sample_ready,
    output logic [1:0]  audio_mode,
    output logic        audio_start_pulse,
    output logic        power_on_pulse,
    output logic        soft_reset_pulse,
    output logic        orphan_sample
`ifdef OPDEC_STATS_EN
    ,
    output logic [15:0] unknown_count
`endif
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC);
    localparam int ONES_W = $clog2(RESET_RUN + 1);

    state_t            state;
    state_t            state_next;
    op_class_t         op_class;
    logic [IDLE_W-1:0] idle_cnt;
    logic [ONES_W-1:0] ones_cnt;

    logic accept;
    logic is_start;
    logic is_sample;
    logic is_all1;
    logic soft_reset;
    logic clear_idle;
    logic timeout;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;

    assign op_ready     = !fifo_full;
    assign sample_valid = !fifo_empty;
    assign audio_mode   = state;

    assign accept    = op_valid && op_ready;
    assign op_class  = classify_op(op);
    assign is_start  = accept && (op_class == OPC_START22 || op_class == OPC_START44);
    assign is_sample = accept && (op_class == OPC_SAMPLE);
    assign is_all1   = accept && (op_class == OPC_ALL1);

    // The all-1 op that completes the run triggers the soft reset directly,
    // so the pulse lands one cycle after that op is accepted.
    assign soft_reset = is_all1 && (ones_cnt == ONES_W'(RESET_RUN - 1));

    // Only samples and starts count as activity for the idle timeout. A
    // clearing op in the timeout cycle keeps the mode alive.
    assign clear_idle = is_sample || is_start;
    assign timeout    = (state != ST_IDLE) && !clear_idle
                        && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    assign fifo_push = is_sample && (state != ST_IDLE);
    assign fifo_pop  = sample_valid && sample_ready;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (op[7:0]),
        .pop       (fifo_pop),
        .pop_data  (sample_data),
        .flush     (soft_reset),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state logic. Soft reset outranks everything, then starts (which
    // also restart a running mode), then the idle timeout.
    always_comb begin
        state_next = state;
        if (soft_reset) begin
            state_next = ST_IDLE;
        end else if (accept && op_class == OPC_START22) begin
            state_next = ST_RUN22;
        end else if (accept && op_class == OPC_START44) begin
            state_next = ST_RUN44;
        end else if (timeout) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            idle_cnt          <= '0;
            ones_cnt          <= '0;
            audio_start_pulse <= 1'b0;
            power_on_pulse    <= 1'b0;
            soft_reset_pulse  <= 1'b0;
            orphan_sample     <= 1'b0;
        end else begin
            state <= state_next;

            // The counter only runs while an audio mode is held; it can never
            // pass TIMEOUT_CYC-1 because the timeout then forces IDLE.
            if (state_next == ST_IDLE || clear_idle) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            // Cycles without an accepted op leave the run count alone.
            if (accept) begin
                if (soft_reset || !is_all1) begin
                    ones_cnt <= '0;
                end else begin
                    ones_cnt <= ones_cnt + 1'b1;
                end
            end

            audio_start_pulse <= is_start;
            power_on_pulse    <= accept && (op_class == OPC_POWER_ON);
            soft_reset_pulse  <= soft_reset;

            if (soft_reset) begin
                orphan_sample <= 1'b0;
            end else if (is_sample && state == ST_IDLE) begin
                orphan_sample <= 1'b1;
            end
        end
    end

`ifdef OPDEC_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unknown_count <= '0;
        end else if (soft_reset) begin
            unknown_count <= '0;
        end else if (accept && op_class == OPC_UNKNOWN && unknown_count != 16'hffff) begin
            unknown_count <= unknown_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_op_stream_decoder.sv
`timescale 1ns/1ps
module tb_op_stream_decoder;

    localparam int DEPTH = 4;
    localparam int RUN   = 2;
    localparam int TOUT  = 64;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [15:0] op;
    logic        op_ready;
    logic        sample_valid;
    logic [7:0]  sample_data;
    logic        sample_ready;
    logic [1:0]  audio_mode;
    logic        audio_start_pulse;
    logic        power_on_pulse;
    logic        soft_reset_pulse;
    logic        orphan_sample;
`ifdef OPDEC_STATS_EN
    logic [15:0] unknown_count;
`endif

    always #5 clk = ~clk;

    op_stream_decoder #(
        .FIFO_DEPTH  (DEPTH),
        .RESET_RUN   (RUN),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .op_valid          (op_valid),
        .op                (op),
        .op_ready          (op_ready),
        .sample_valid      (sample_valid),
        .sample_data       (sample_data),
        .sample_ready      (sample_ready),
        .audio_mode        (audio_mode),
        .audio_start_pulse (audio_start_pulse),
        .power_on_pulse    (power_on_pulse),
        .soft_reset_pulse  (soft_reset_pulse),
        .orphan_sample     (orphan_sample)
`ifdef OPDEC_STATS_EN
        ,
        .unknown_count     (unknown_count)
`endif
    );

    // Edge counter: after rising edge n (counted from reset release) cyc == n.
    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode: 0 idle, 1 22k, 2 44k. m_last is the edge of the last sample/start.
    logic [7:0] exp_q[$];
    int  m_mode, m_last, m_ones, m_unknown;
    bit  m_orphan;
    bit  e_start, e_power, e_soft;
    int  exp_start_n = 0, exp_power_n = 0, exp_soft_n = 0;

    task automatic model_reset();
        m_mode = 0; m_last = 0; m_ones = 0; m_unknown = 0; m_orphan = 0;
        exp_q.delete();
    endtask

    // Mode seen after edge n: a held mode lapses TOUT edges after activity.
    function automatic int mode_at(input int n);
        if (m_mode != 0 && n - m_last >= TOUT) return 0;
        return m_mode;
    endfunction

    task automatic model_apply(input logic [15:0] w, input int a);
        int m;
        // Mode in force while the op is taken is the one after edge a-1.
        m = (m_mode != 0 && a - m_last > TOUT) ? 0 : m_mode;
        m_mode = m;
        e_start = 0; e_power = 0; e_soft = 0;
        if (w == 16'hc5ef) begin
            e_power = 1; m_ones = 0;
        end else if (w[15:8] == 8'h1f || w[15:8] == 8'h0f) begin
            m_mode = (w[15:8] == 8'h1f) ? 1 : 2;
            m_last = a; e_start = 1; m_ones = 0;
        end else if (w[15:8] == 8'hc7) begin
            m_ones = 0;
            if (m == 0) m_orphan = 1;
            else begin exp_q.push_back(w[7:0]); m_last = a; end
        end else if (w[15:8] == 8'hff) begin
            m_ones++;
            if (m_ones == RUN) begin
                e_soft = 1; m_mode = 0; m_ones = 0; m_orphan = 0; m_unknown = 0;
                exp_q.delete();
            end
        end else begin
            m_ones = 0;
            if (m_unknown < 65535) m_unknown++;
        end
        if (e_start) exp_start_n++;
        if (e_power) exp_power_n++;
        if (e_soft)  exp_soft_n++;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int seen_start_n = 0, seen_power_n = 0, seen_soft_n = 0, delivered = 0;

    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            if (audio_start_pulse) seen_start_n++;
            if (power_on_pulse)    seen_power_n++;
            if (soft_reset_pulse)  seen_soft_n++;
            if (sample_valid && sample_ready) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sample_unexpected: got 0x%0h expected no sample", sample_data);
                end else begin
                    check("sample_data", sample_data, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int last_accept;

    task automatic send_op(input logic [15:0] w);
        int waited;
        waited = 0;
        @(negedge clk);
        op = w;
        op_valid = 1'b1;
        while (!op_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) begin
            checks++; errors++;
            $display("FAIL op_accept_timeout: op 0x%04h got op_ready=0 expected 1 within 200 cycles", w);
            op_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        last_accept = cyc;
        model_apply(w, cyc);
        check("start_pulse", audio_start_pulse, e_start);
        check("power_pulse", power_on_pulse, e_power);
        check("soft_pulse", soft_reset_pulse, e_soft);
        check("orphan", orphan_sample, m_orphan);
        check("audio_mode", audio_mode, mode_at(cyc));
        check("sample_valid", sample_valid, exp_q.size() != 0);
        check("op_ready", op_ready, exp_q.size() < DEPTH);
        if (exp_q.size() != 0) check("sample_head", sample_data, exp_q[0]);
`ifdef OPDEC_STATS_EN
        check("unknown_count", unknown_count, m_unknown);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_mode"}, audio_mode, 2'b00);
        check({tag, "_sample_valid"}, sample_valid, 1'b0);
        check({tag, "_op_ready"}, op_ready, 1'b1);
        check({tag, "_start_pulse"}, audio_start_pulse, 1'b0);
        check({tag, "_power_pulse"}, power_on_pulse, 1'b0);
        check({tag, "_soft_pulse"}, soft_reset_pulse, 1'b0);
        check({tag, "_orphan"}, orphan_sample, 1'b0);
`ifdef OPDEC_STATS_EN
        check({tag, "_unknown_count"}, unknown_count, 16'h0);
`endif
    endtask

    bit rand_ready_en = 0;
    always begin
        @(negedge clk);
        if (rand_ready_en) sample_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base_soft, base_del, r;
        logic [15:0] w;

        reset = 1'b1; op_valid = 1'b0; op = 16'h0; sample_ready = 1'b0;
        model_reset();
        idle(3);
        check_reset_state("reset");
        reset = 1'b0;

        // Start 22k, two samples delivered in order.
        sample_ready = 1'b1;
        send_op(16'h1f05);
        send_op(16'hc712);
        send_op(16'hc734);
        idle(5);
        check("basic_drained", exp_q.size(), 0);
        check("basic_delivered", delivered, 2);
        check("basic_start_count", seen_start_n, 1);

        // Back-pressure in 44k: six samples into a four-entry FIFO.
        sample_ready = 1'b0;
        send_op(16'h0f00);
        for (int i = 0; i < DEPTH; i++) send_op({8'hc7, 8'(8'h40 + i)});
        @(negedge clk);
        check("bp_op_ready_full", op_ready, 1'b0);
        base_del = delivered;
        fork
            begin
                send_op(16'hc750);
                send_op(16'hc751);
            end
            begin
                idle(6);
                sample_ready = 1'b1;
            end
        join
        idle(10);
        check("bp_drained", exp_q.size(), 0);
        check("bp_delivered", delivered - base_del, DEPTH + 2);

        // All-1 runs: an interrupted run must not soft-reset.
        sample_ready = 1'b0;
        send_op(16'h1f00);
        send_op(16'hc7aa);
        base_soft = seen_soft_n;
        send_op(16'hff00);
        send_op(16'h1234);
        send_op(16'hffaa);
        idle(2);
        check("run_interrupted_soft", seen_soft_n - base_soft, 0);
        send_op(16'hff00);
        send_op(16'hffff);
        idle(2);
        check("run_soft_count", seen_soft_n - base_soft, 1);
        check("run_mode_idle", audio_mode, 2'b00);
        check("run_fifo_empty", sample_valid, 1'b0);
`ifdef OPDEC_STATS_EN
        send_op(16'h1234);
        send_op(16'habcd);
        check("stats_unknown_two", unknown_count, 16'd2);
`endif

        // Orphan sample while idle, then power-on keeps the flag.
        sample_ready = 1'b1;
        base_del = delivered;
        send_op(16'hc799);
        idle(3);
        check("orphan_set", orphan_sample, 1'b1);
        check("orphan_no_output", delivered - base_del, 0);
        send_op(16'hc5ef);
        check("power_keeps_orphan", orphan_sample, 1'b1);

        // Timeout: 44k restart with two buffered samples, then silence.
        sample_ready = 1'b0;
        send_op(16'h1f00);
        send_op(16'hc7a1);
        send_op(16'hc7a2);
        send_op(16'h0f00);
        wait_until(last_accept + TOUT - 1);
        check("timeout_before", audio_mode, 2'b10);
        wait_until(last_accept + TOUT);
        check("timeout_at", audio_mode, 2'b00);
        check("timeout_fifo_kept", sample_valid, 1'b1);
        base_del = delivered;
        @(negedge clk);
        sample_ready = 1'b1;
        idle(6);
        check("timeout_drained", delivered - base_del, 2);

        // Randomized traffic against the model.
        rand_ready_en = 1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       w = {8'h1f, 8'($urandom)};
                1:       w = {8'h0f, 8'($urandom)};
                2,3,4,5: w = {8'hc7, 8'($urandom)};
                6,7:     w = {8'hff, 8'($urandom)};
                8:       w = 16'hc5ef;
                default: w = 16'($urandom);
            endcase
            send_op(w);
            if ($urandom_range(0, 19) == 0) idle(TOUT + 6);
            else idle($urandom_range(0, 2));
        end
        rand_ready_en = 0;
        @(negedge clk);
        sample_ready = 1'b1;
        idle(DEPTH + 10);
        check("rand_drained", exp_q.size(), 0);
        check("start_total", seen_start_n, exp_start_n);
        check("power_total", seen_power_n, exp_power_n);
        check("soft_total", seen_soft_n, exp_soft_n);

        // Reset in the middle of activity.
        sample_ready = 1'b0;
        send_op(16'h0f00);
        send_op(16'hc701);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_state("midreset");
        idle(2);
        reset = 1'b0;
        idle(2);
        check("post_reset_mode", audio_mode, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
